counter_0_9_ctrl: RTL and testbench
===================================

Name: counter_0_9_ctrl

Overview:
Run-control sequencer for the 0-9 count stage. Replaces the divided-clock scheme with a single-clock design: an internal prescaler produces a one-cycle step enable, and the BCD digit advances only on that enable. An FSM (IDLE/RUN/PAUSE/DONE) handles start, stop, clear, preset load, count direction and one-shot mode. Sits between the board button/switch synchronizers and the 7-segment digit driver.

Parameters:
TICK_DIV, 50000000, clk cycles per count step (>=2); benches use 4.
PS_W, 26, prescaler width; must satisfy 2^PS_W >= TICK_DIV.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse, synchronized upstream.
stop  input  1  single-cycle pulse.
clear  input  1  single-cycle pulse.
load  input  1  single-cycle pulse; preset from load_val.
load_val  input  4  preset value; values above 9 are clipped to 9.
dir  input  1  1 = count up, 0 = count down; sampled on each step.
one_shot  input  1  1 = stop at terminal value; 0 = wrap around.
q  output  4  current BCD digit, 0..9.
tick  output  1  registered; high for the one cycle after each q step.
tc  output  1  registered; high for the one cycle after q reaches a terminal value (9 up, 0 down) by stepping.
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
running  output  1  1 when state is RUN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, q=0, prescaler=0, tick=0, tc=0, running=0. On release, the first active edge evaluates inputs normally.
- Input priority in the same cycle: clear > load > stop > start. Lower-priority pulses in that cycle are dropped.
- clear (any state): state=IDLE, q=0, prescaler=0.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - q = min(load_val, 9).
  - IDLE and PAUSE keep their state; DONE goes to IDLE.
  - Prescaler is not changed.
- start:
  - IDLE -> RUN with prescaler=0.
  - PAUSE -> RUN; prescaler resumes from its held value.
  - DONE -> RUN with q = 0 if dir=1, or 9 if dir=0, and prescaler=0.
  - Ignored in RUN.
- stop: RUN -> PAUSE; ignored in all other states. In PAUSE, the prescaler and q are frozen.
- Prescaler: increments only in RUN. When prescaler = TICK_DIV-1 on an edge, it wraps to 0 and a step occurs on that same edge.
- Step, dir=1:
  - q<9: q+1.
  - q=9 and one_shot=0: q=0.
  - q=9 and one_shot=1: q stays 9 and state goes to DONE.
- Step, dir=0: mirror of the above (q-1, 0 wraps to 9, one_shot holds 0 and goes to DONE).
- Terminal hold counts as a step for tick. It does not set tc.
- tc is set whenever a step makes q land on the terminal value for the current dir. A wrap therefore asserts tc one step before the wrap occurs.
- First step after start from IDLE happens TICK_DIV edges after the start edge. Steady-state period is TICK_DIV cycles.
- stop coincident with a wrap edge: stop wins. No step occurs, the prescaler holds TICK_DIV-1, and the step happens on the first RUN edge after resume.
- Changing dir mid-run takes effect at the next step only. No glitch on q.
- q is never outside 0..9. The counter must recover if an illegal value is forced: any q>9 steps to 0.
- tick and tc are 0 in every cycle that does not follow a step, including after clear, load and reset.

Test Plan:
- Basic up count, TICK_DIV=4: reset, start, dir=1, one_shot=0 -> q steps 0,1,...,9,0 every 4 clocks, first step 4 clocks after start; tc pulses once after q becomes 9; 10 tick pulses per cycle.
- Pause and resume: start, wait 6 clocks (q=1, prescaler=2), stop -> q holds 1 for 20 clocks, state=10; start -> q=2 exactly 2 clocks later.
- Down one-shot: load load_val=3, start, dir=0, one_shot=1 -> q=2,1,0, tc after 0; next step holds q=0, state=DONE, tick=1, tc=0; start -> q=9, state=RUN.
- Priority and clip: in PAUSE, pulse clear+load+start together -> state=IDLE, q=0; then load load_val=12 -> q=9; load during RUN is ignored.
- Stop on wrap edge: assert stop on the edge where prescaler=3 -> no step, state=PAUSE; start -> step on the next edge.
- Async reset mid-count: drop reset between clock edges while q=7 -> q=0 and state=IDLE immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/counter_0_9_ctrl.sv
// -----------------------------------------------------------------------------
// counter_0_9_ctrl
//
// Run-control sequencer for the 0-9 count stage. Everything runs on a single
// clock: a prescaler counts TICK_DIV cycles while the FSM is in RUN and the
// BCD digit advances only on the cycle the prescaler wraps. The FSM
// (IDLE/RUN/PAUSE/DONE) handles start, stop, clear, preset load, count
// direction and one-shot (stop at terminal value) operation.
//
// Parameters:
//   TICK_DIV  clk cycles per count step (>= 2)
//   PS_W      prescaler width, 2**PS_W >= TICK_DIV
//
// Ports:
//   clk       system clock, rising-edge active
//   reset     asynchronous active-low reset
//   start     pulse: IDLE/PAUSE/DONE -> RUN
//   stop      pulse: RUN -> PAUSE
//   clear     pulse: any state -> IDLE, q = 0
//   load      pulse: preset q from load_val (not in RUN)
//   load_val  preset value, clipped to 9
//   dir       1 = count up, 0 = count down (sampled on each step)
//   one_shot  1 = hold at terminal value and enter DONE, 0 = wrap
//   q         current BCD digit 0..9
//   tick      registered, high the cycle after each step
//   tc        registered, high the cycle after a step lands on the terminal
//             value for the current direction (9 up, 0 down)
//   state     IDLE=00, RUN=01, PAUSE=10, DONE=11
//   running   high while state is RUN
// -----------------------------------------------------------------------------
module counter_0_9_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int PS_W     = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dir,
  input  logic       one_shot,
  output logic [3:0] q,
  output logic       tick,
  output logic       tc,
  output logic [1:0] state,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t          state_q, state_d;
  logic [3:0]      q_q, q_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_q, tick_d;
  logic            tc_q, tc_d;

  logic [3:0] load_clip;
  logic       ps_wrap;

  assign load_clip = (load_val > 4'd9) ? 4'd9 : load_val;
  assign ps_wrap   = (ps_q == PS_LAST);

  // Pulses are decoded in priority order clear > load > stop > start. A pulse
  // that has no meaning in the current state (load or start in RUN, stop
  // outside RUN) is treated as absent, so it does not mask the ones below it.
  always_comb begin
    // NOTE: every variable driven here gets a default first; without it any
    // path that skips an assignment would infer a latch.
    state_d = state_q;
    q_d     = q_q;
    ps_d    = ps_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    if (clear) begin
      state_d = IDLE;
      q_d     = 4'd0;
      ps_d    = '0;
    end else if (load && (state_q != RUN)) begin
      // Prescaler deliberately untouched so a paused run resumes in phase.
      q_d = load_clip;
      if (state_q == DONE) state_d = IDLE;
    end else if (stop && (state_q == RUN)) begin
      // Stop wins over a coincident wrap: no step, prescaler keeps its value
      // and the step fires on the first RUN edge after resume.
      state_d = PAUSE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
      case (state_q)
        IDLE:    ps_d = '0;
        DONE: begin
          ps_d = '0;
          q_d  = dir ? 4'd0 : 4'd9;
        end
        default: ;  // PAUSE resumes from the held prescaler value
      endcase
    end else if (state_q == RUN) begin
      if (ps_wrap) begin
        ps_d   = '0;
        tick_d = 1'b1;   // a terminal hold is still a step for tick
        if (q_q > 4'd9) begin
          // Recovery from an illegal digit; 0 is terminal only when counting down.
          q_d  = 4'd0;
          tc_d = ~dir;
        end else if (dir) begin
          if (q_q == 4'd9) begin
            if (one_shot) state_d = DONE;
            else          q_d     = 4'd0;
          end else begin
            q_d  = q_q + 4'd1;
            tc_d = (q_q == 4'd8);
          end
        end else begin
          if (q_q == 4'd0) begin
            if (one_shot) state_d = DONE;
            else          q_d     = 4'd9;
          end else begin
            q_d  = q_q - 4'd1;
            tc_d = (q_q == 4'd1);
          end
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= 4'd0;
      ps_q    <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ps_q    <= ps_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign q       = q_q;
  assign tick    = tick_q;
  assign tc      = tc_q;
  assign state   = state_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_counter_0_9_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_0_9_ctrl
//
// Directed bench for counter_0_9_ctrl with TICK_DIV = 4. Each step drives the
// inputs, pushes the digit/state/tick/tc expected after the next edge into a
// scoreboard queue, and pops and compares #1 after that edge.
// -----------------------------------------------------------------------------
module tb_counter_0_9_ctrl;

  localparam int TICK_DIV = 4;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic       clk;
  logic       reset;
  logic       start, stop, clear, load;
  logic [3:0] load_val;
  logic       dir, one_shot;
  logic [3:0] q;
  logic       tick, tc;
  logic [1:0] state;
  logic       running;

  counter_0_9_ctrl #(.TICK_DIV(TICK_DIV), .PS_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .one_shot (one_shot),
    .q        (q),
    .tick     (tick),
    .tc       (tc),
    .state    (state),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic [1:0] st;
    logic       tick;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] eq, input logic [1:0] es,
                      input logic et, input logic ec);
    exp_t e;
    e.tag = tag; e.q = eq; e.st = es; e.tick = et; e.tc = ec;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "/q"},       8'(q),       8'(e.q));
      check({e.tag, "/state"},   8'(state),   8'(e.st));
      check({e.tag, "/tick"},    8'(tick),    8'(e.tick));
      check({e.tag, "/tc"},      8'(tc),      8'(e.tc));
      check({e.tag, "/running"}, 8'(running), 8'(e.st == S_RUN));
    end
  endtask

  // One clock: pulses are sampled on the edge, dropped #1 later, then the
  // pending expectation (if any) is compared.
  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    if (exp_q.size() != 0) pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] eq;
    logic       et, ec;
    int         n_tick, n_tc;

    reset = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = 4'd0; dir = 1'b1; one_shot = 1'b0;

    // Reset state
    #2;
    push("reset", 4'd0, S_IDLE, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    reset = 1'b1;
    push("post_reset", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();

    // Basic up count with wrap
    dir = 1'b1; one_shot = 1'b0; start = 1'b1;
    push("up_start", 4'd0, S_RUN, 1'b0, 1'b0);
    cyc();
    n_tick = 0; n_tc = 0;
    for (int k = 1; k <= 40; k++) begin
      eq = 4'((k / TICK_DIV) % 10);
      et = (k % TICK_DIV == 0);
      ec = et && (eq == 4'd9);
      push("up_run", eq, S_RUN, et, ec);
      cyc();
      if (tick) n_tick++;
      if (tc)   n_tc++;
    end
    check("up_tick_count", 8'(n_tick), 8'd10);
    check("up_tc_count",   8'(n_tc),   8'd1);

    // Load while running is ignored
    load = 1'b1; load_val = 4'd5;
    push("load_in_run", 4'd0, S_RUN, 1'b0, 1'b0);
    cyc();
    clear = 1'b1;
    push("clear_run", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();

    // Pause and resume: stop after 6 clocks (q=1, prescaler=2)
    start = 1'b1;
    push("pr_start", 4'd0, S_RUN, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 6; k++) begin
      push("pr_run", (k >= 4) ? 4'd1 : 4'd0, S_RUN, (k == 4), 1'b0);
      cyc();
    end
    stop = 1'b1;
    push("pr_stop", 4'd1, S_PAUSE, 1'b0, 1'b0);
    cyc();
    for (int k = 0; k < 20; k++) begin
      push("pr_hold", 4'd1, S_PAUSE, 1'b0, 1'b0);
      cyc();
    end
    start = 1'b1;
    push("pr_resume", 4'd1, S_RUN, 1'b0, 1'b0);
    cyc();
    push("pr_resume1", 4'd1, S_RUN, 1'b0, 1'b0);
    cyc();
    push("pr_resume2", 4'd2, S_RUN, 1'b1, 1'b0);
    cyc();
    stop = 1'b1;
    push("pr_stop2", 4'd2, S_PAUSE, 1'b0, 1'b0);
    cyc();

    // Priority clear > load > start in PAUSE, then clipped load
    clear = 1'b1; load = 1'b1; load_val = 4'd7; start = 1'b1;
    push("prio", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();
    load = 1'b1; load_val = 4'd12;
    push("clip", 4'd9, S_IDLE, 1'b0, 1'b0);
    cyc();

    // Stop on the wrap edge (prescaler=3), then wrap 9 -> 0 on resume
    start = 1'b1;
    push("sw_start", 4'd9, S_RUN, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 3; k++) begin
      push("sw_run", 4'd9, S_RUN, 1'b0, 1'b0);
      cyc();
    end
    stop = 1'b1;
    push("sw_stop", 4'd9, S_PAUSE, 1'b0, 1'b0);
    cyc();
    push("sw_hold", 4'd9, S_PAUSE, 1'b0, 1'b0);
    cyc();
    start = 1'b1;
    push("sw_resume", 4'd9, S_RUN, 1'b0, 1'b0);
    cyc();
    push("sw_step", 4'd0, S_RUN, 1'b1, 1'b0);
    cyc();
    clear = 1'b1;
    push("sw_clear", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();

    // Down count, one-shot, from preset 3
    load = 1'b1; load_val = 4'd3;
    push("dn_load", 4'd3, S_IDLE, 1'b0, 1'b0);
    cyc();
    dir = 1'b0; one_shot = 1'b1; start = 1'b1;
    push("dn_start", 4'd3, S_RUN, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 16; k++) begin
      et = (k % TICK_DIV == 0);
      if (k < 16) begin
        eq = 4'(3 - k / TICK_DIV);
        push("dn_run", eq, S_RUN, et, et && (eq == 4'd0));
      end else begin
        push("dn_hold", 4'd0, S_DONE, 1'b1, 1'b0);
      end
      cyc();
    end
    push("dn_done", 4'd0, S_DONE, 1'b0, 1'b0);
    cyc();
    start = 1'b1;
    push("dn_restart", 4'd9, S_RUN, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      push("dn_rerun", (k == 4) ? 4'd8 : 4'd9, S_RUN, (k == 4), 1'b0);
      cyc();
    end

    // Asynchronous reset mid-count at q=7
    clear = 1'b1;
    push("ar_clear", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();
    dir = 1'b1; one_shot = 1'b0; start = 1'b1;
    push("ar_start", 4'd0, S_RUN, 1'b0, 1'b0);
    cyc();
    for (int k = 1; k <= 28; k++) begin
      et = (k % TICK_DIV == 0);
      push("ar_run", 4'((k / TICK_DIV) % 10), S_RUN, et, 1'b0);
      cyc();
    end
    #2;
    reset = 1'b0;
    #1;
    push("ar_async", 4'd0, S_IDLE, 1'b0, 1'b0);
    pop_check();
    @(negedge clk);
    reset = 1'b1;
    push("ar_release", 4'd0, S_IDLE, 1'b0, 1'b0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
